// File: rtl/shift_sequencer.sv
// Command sequencer for the 8-bit shifter. It drives one LOAD cycle, then
// `count` shift cycles, and hands back the shifter's registered byte over a
// valid/ready handshake.
// Optional build macro SHIFT_SEQUENCER_CMD_FIFO_EN adds a 2-entry command FIFO.
// With the FIFO, cmd_ready means "FIFO not full", and finished results can
// chain straight into the next LOAD.
module shift_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_shamt,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [7:0]       cmd_data,
  output logic [2:0]       sh_op,
  output logic [1:0]       sh_shamt,
  output logic [7:0]       sh_d_in,
  input  logic [7:0]       sh_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             busy
);

  localparam int unsigned CMD_W = 3 + 2 + CNT_W + 8;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q;
  logic [1:0]       shamt_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       data_q;

  logic [CMD_W-1:0] cmd_in, load_val;
  logic             load_cmd;
  logic [2:0]       ld_op, op_n;
  logic [1:0]       ld_shamt, shamt_n;
  logic [CNT_W-1:0] ld_count;
  logic [7:0]       ld_data, data_n;

  logic [2:0]       sh_op_d;
  logic [1:0]       sh_shamt_d;
  logic [7:0]       sh_d_in_d;
  logic             cmd_ready_d;

  assign cmd_in   = {cmd_op, cmd_shamt, cmd_count, cmd_data};
  assign ld_op    = load_val[CMD_W-1 -: 3];
  assign ld_shamt = load_val[CMD_W-4 -: 2];
  assign ld_count = load_val[CNT_W+7 -: CNT_W];
  assign ld_data  = load_val[7:0];

`ifdef SHIFT_SEQUENCER_CMD_FIFO_EN
  logic [CMD_W-1:0] fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_cnt, fifo_cnt_d;
  logic             fifo_push, fifo_pop;
  logic [CMD_W-1:0] fifo_head;

  assign fifo_head  = fifo_mem[rd_ptr];
  assign fifo_cnt_d = fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);

  // FIFO storage (no reset needed, occupancy is tracked separately)
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= cmd_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (fifo_push) wr_ptr <= ~wr_ptr;
      if (fifo_pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt_d;
    end
  end
`endif

  // Next state, step counter and command-load selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_cmd = 1'b0;
    load_val = cmd_in;
`ifdef SHIFT_SEQUENCER_CMD_FIFO_EN
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef SHIFT_SEQUENCER_CMD_FIFO_EN
        if (fifo_cnt != 2'd0) begin
          fifo_pop = 1'b1;
          load_cmd = 1'b1;
          load_val = fifo_head;
          state_d  = S_LOAD;
        end else if (cmd_valid && cmd_ready) begin
          load_cmd = 1'b1;
          state_d  = S_LOAD;
        end
`else
        if (cmd_valid && cmd_ready) begin
          load_cmd = 1'b1;
          state_d  = S_LOAD;
        end
`endif
      end
      S_LOAD: begin
        cnt_d   = count_q;
        state_d = (count_q != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
`ifdef SHIFT_SEQUENCER_CMD_FIFO_EN
          if (fifo_cnt != 2'd0) begin
            fifo_pop = 1'b1;
            load_cmd = 1'b1;
            load_val = fifo_head;
            state_d  = S_LOAD;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SHIFT_SEQUENCER_CMD_FIFO_EN
    // An IDLE accept with an empty FIFO bypasses storage
    fifo_push = cmd_valid && cmd_ready && !(state_q == S_IDLE && fifo_cnt == 2'd0);
`endif
  end

  assign op_n    = load_cmd ? ld_op    : op_q;
  assign shamt_n = load_cmd ? ld_shamt : shamt_q;
  assign data_n  = load_cmd ? ld_data  : data_q;

  // Output values for the state being entered, so the ports register cleanly
  always_comb begin
    sh_op_d    = OP_NOP;
    sh_shamt_d = 2'd0;
    sh_d_in_d  = 8'h00;
    unique case (state_d)
      S_LOAD:  sh_op_d = OP_LOAD;
      S_SHIFT: sh_op_d = op_n;
      default: sh_op_d = OP_NOP;
    endcase
    if (state_d != S_IDLE) begin
      sh_shamt_d = shamt_n;
      sh_d_in_d  = data_n;
    end
`ifdef SHIFT_SEQUENCER_CMD_FIFO_EN
    cmd_ready_d = (fifo_cnt_d != 2'd2);
`else
    cmd_ready_d = (state_d == S_IDLE);
`endif
  end

  // State, counter, latched command and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 3'd0;
      shamt_q   <= 2'd0;
      count_q   <= '0;
      data_q    <= 8'h00;
      sh_op     <= OP_NOP;
      sh_shamt  <= 2'd0;
      sh_d_in   <= 8'h00;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_cmd) begin
        op_q    <= ld_op;
        shamt_q <= ld_shamt;
        count_q <= ld_count;
        data_q  <= ld_data;
      end
      sh_op     <= sh_op_d;
      sh_shamt  <= sh_shamt_d;
      sh_d_in   <= sh_d_in_d;
      res_valid <= (state_d == S_DONE);
      busy      <= (state_d != S_IDLE);
      cmd_ready <= cmd_ready_d;
    end
  end

  // The shifter register is held by NOP in DONE, so its output is the result
  assign res_data = (state_q == S_DONE) ? sh_q : 8'h00;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (default build, no command FIFO).
module tb_shift_sequencer;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_shamt;
  logic [CNT_W-1:0] cmd_count;
  logic [7:0]       cmd_data;
  logic [2:0]       sh_op;
  logic [1:0]       sh_shamt;
  logic [7:0]       sh_d_in;
  logic [7:0]       sh_q;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             busy;

  shift_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_shamt(cmd_shamt), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .sh_op(sh_op), .sh_shamt(sh_shamt), .sh_d_in(sh_d_in), .sh_q(sh_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream 8-bit shifter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh_q <= 8'h00;
    else begin
      case (sh_op)
        3'b001:  sh_q <= sh_d_in;
        3'b010:  sh_q <= sh_q << sh_shamt;
        3'b011:  sh_q <= sh_q >> sh_shamt;
        3'b100:  sh_q <= 8'($signed(sh_q) >>> sh_shamt);
        default: sh_q <= sh_q;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         due;
    int         bp;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] cur_data = 8'h00;
  logic [1:0] cur_shamt = 2'd0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Closed-form result: total shift = shamt*count applied once
  function automatic logic [7:0] ref_result(input logic [7:0] d, input logic [2:0] op,
                                            input int sh, input int cnt);
    int total;
    int v;
    total = sh * cnt;
    case (op)
      3'b010: v = (total >= 8) ? 0 : ((int'(d) << total) & 255);
      3'b011: v = (total >= 8) ? 0 : (int'(d) >> total);
      3'b100: begin
        v = int'($signed(d));
        v = (total >= 8) ? ((v < 0) ? 255 : 0) : ((v >>> total) & 255);
      end
      default: v = int'(d);
    endcase
    return 8'(v);
  endfunction

  task automatic send(input logic [2:0] op, input logic [1:0] sh, input int cnt,
                      input logic [7:0] d, input int bp, input bit expect_result);
    int guard;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_shamt = sh;
    cmd_count = CNT_W'(cnt);
    cmd_data  = d;
    guard = 0;
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    // Accepted at the coming edge E0 = cyc + 1
    cur_data  = d;
    cur_shamt = sh;
    if (expect_result) begin
      e.data = ref_result(d, op, int'(sh), cnt);
      e.due  = cyc + 1 + cnt + 1;
      e.bp   = bp;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on handshake
  initial begin
    bit         prev_v;
    bit         hs;
    int         hold;
    logic [7:0] held;
    exp_t       e;
    prev_v = 1'b0;
    hold = 0;
    held = 8'h00;
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_v = 1'b0;
        hold = 0;
        continue;
      end
      check("cmd_ready_vs_busy", int'(cmd_ready), int'(!busy));
      if (!busy) begin
        check("idle_sh_op", int'(sh_op), 0);
        check("idle_sh_d_in", int'(sh_d_in), 0);
        check("idle_res_valid", int'(res_valid), 0);
      end else begin
        check("busy_sh_d_in", int'(sh_d_in), int'(cur_data));
        check("busy_sh_shamt", int'(sh_shamt), int'(cur_shamt));
      end
      if (res_valid) begin
        check("done_sh_op_nop", int'(sh_op), 0);
        if (!prev_v) begin
          if (exp_q.size() == 0) check("unexpected_result", 1, 0);
          else begin
            check("latency_cycle", cyc, exp_q[0].due);
            hold = exp_q[0].bp;
          end
          held = res_data;
        end else begin
          check("res_data_stable", int'(res_data), int'(held));
        end
      end
      if (hold > 0) begin
        res_ready = 1'b0;
        hold--;
      end else begin
        res_ready = ($urandom_range(0, 3) != 0);
      end
      hs = res_valid && res_ready;
      if (hs && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_data", int'(res_data), int'(e.data));
      end
      prev_v = res_valid && !hs;
    end
  end

  // Stimulus
  initial begin
    int guard;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_shamt = 2'd0;
    cmd_count = '0;
    cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sh_op", int'(sh_op), 0);
    check("rst_sh_shamt", int'(sh_shamt), 0);
    check("rst_sh_d_in", int'(sh_d_in), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);

    // Reset in the middle of a long shift run
    send(3'b010, 2'd1, 12, 8'hC3, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_busy_before_reset", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_sh_op", int'(sh_op), 0);
    check("mid_rst_res_valid", int'(res_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_sh_d_in", int'(sh_d_in), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_data  = 8'h00;
    cur_shamt = 2'd0;

    // Directed cases
    send(3'b010, 2'd1, 3, 8'h81, 0, 1'b1);   // LSL -> 0x08
    send(3'b100, 2'd2, 2, 8'h80, 0, 1'b1);   // ASR -> 0xF8
    send(3'b011, 2'd3, 0, 8'hF0, 5, 1'b1);   // zero count, back-pressure
    send(3'b111, 2'd1, 4, 8'h5A, 0, 1'b1);   // invalid op keeps data
    send(3'b011, 2'd1, 15, 8'hFF, 0, 1'b1);  // max count, 15 steps -> 0
    send(3'b100, 2'd0, 15, 8'h9C, 2, 1'b1);  // max count with zero shamt
    send(3'b010, 2'd1, 7, 8'h01, 0, 1'b1);   // LSL to the top bit -> 0x80

    // Randomised commands
    for (int i = 0; i < 30; i++) begin
      send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), 8'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end

    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
